// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch address and offers it to instruction memory
// over a valid/ready handshake. Advances sequentially, on redirect, or on trap entry.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     STEP         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcp4_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            misalign_reg, misalign_next;
  logic [XLEN-1:0] misalign_addr_reg, misalign_addr_next;
  logic            fetch_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= BOOT;
      pc_reg            <= RESET_VECTOR;
      misalign_reg      <= 1'b0;
      misalign_addr_reg <= '0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      misalign_reg      <= misalign_next;
      misalign_addr_reg <= misalign_addr_next;
    end
  end

  // A redirect or trap in the same cycle flushes the request, so nothing is issued then.
  assign fetch_valid = (state_reg == RUN) && !stall_i && !redirect_valid_i && !trap_valid_i;

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    misalign_next      = misalign_reg;
    misalign_addr_next = misalign_addr_reg;

    if (trap_valid_i) begin
      pc_next       = {trap_vector_i[XLEN-1:2], 2'b00};
      state_next    = RUN;
      misalign_next = 1'b0;
    end else begin
      case (state_reg)
        BOOT: state_next = RUN;
        RUN: begin
          if (redirect_valid_i) begin
            if (redirect_target_i[1:0] == 2'b00) begin
              pc_next = redirect_target_i;
            end else begin
              // Misaligned target: keep the old PC and stop fetching until a trap arrives.
              state_next         = HALT;
              misalign_next      = 1'b1;
              misalign_addr_next = redirect_target_i;
            end
          end else if (fetch_valid && fetch_ready_i) begin
            pc_next = pc_reg + STEP_W;
          end
        end
        HALT:    state_next = HALT;
        default: state_next = BOOT;
      endcase
    end
  end

  assign fetch_valid_o   = fetch_valid;
  assign pc_o            = pc_reg;
  assign pcp4_o          = pc_reg + STEP_W;
  assign misalign_o      = misalign_reg;
  assign misalign_addr_o = misalign_addr_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with RESET_VECTOR = 0x100.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic            stall_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_target_i;
  logic            trap_valid_i;
  logic [XLEN-1:0] trap_vector_i;
  logic            fetch_ready_i;
  logic            fetch_valid_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pcp4_o;
  logic            misalign_o;
  logic [XLEN-1:0] misalign_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  pc_gen #(
    .XLEN(XLEN),
    .RESET_VECTOR(32'h0000_0100),
    .STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_target_i(redirect_target_i),
    .trap_valid_i(trap_valid_i),
    .trap_vector_i(trap_vector_i),
    .fetch_ready_i(fetch_ready_i),
    .fetch_valid_o(fetch_valid_o),
    .pc_o(pc_o),
    .pcp4_o(pcp4_o),
    .misalign_o(misalign_o),
    .misalign_addr_o(misalign_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall_i           = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_target_i = '0;
    trap_valid_i      = 1'b0;
    trap_vector_i     = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    fetch_ready_i = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    #1;
    n_cmp++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL reset_pc actual=%h required=%h", pc_o, 32'h100); end
    n_cmp++; if (fetch_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid actual=%b required=0", fetch_valid_o); end
    n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL reset_misalign actual=%b required=0", misalign_o); end
    n_cmp++; if (misalign_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_maddr actual=%h required=0", misalign_addr_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if (fetch_valid_o !== 1'b0) begin n_err++; $display("FAIL boot_valid actual=%b required=0", fetch_valid_o); end
    $display("reset: pc=%h valid=%b", pc_o, fetch_valid_o);
  endtask

  task automatic test_free_run();
    logic [XLEN-1:0] exp_pc [3];
    exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_cmp++; if (pc_o !== exp_pc[i]) begin n_err++; $display("FAIL run_pc%0d actual=%h required=%h", i, pc_o, exp_pc[i]); end
      n_cmp++; if (pcp4_o !== exp_pc[i] + 32'h4) begin n_err++; $display("FAIL run_pcp4_%0d actual=%h required=%h", i, pcp4_o, exp_pc[i] + 32'h4); end
      n_cmp++; if (fetch_valid_o !== 1'b1) begin n_err++; $display("FAIL run_valid%0d actual=%b required=1", i, fetch_valid_o); end
      $display("fetch: pc=%h pcp4=%h valid=%b", pc_o, pcp4_o, fetch_valid_o);
    end
  endtask

  task automatic test_backpressure();
    redirect_valid_i = 1'b1; redirect_target_i = 32'h10;
    #1;
    n_cmp++; if (fetch_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_cycle_valid actual=%b required=0", fetch_valid_o); end
    tick();
    clear_inputs();
    fetch_ready_i = 1'b0;
    #1;
    n_cmp++; if (pc_o !== 32'h10) begin n_err++; $display("FAIL bp_start_pc actual=%h required=%h", pc_o, 32'h10); end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_cmp++; if (pc_o !== 32'h10) begin n_err++; $display("FAIL bp_hold_pc%0d actual=%h required=%h", i, pc_o, 32'h10); end
      n_cmp++; if (fetch_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid%0d actual=%b required=1", i, fetch_valid_o); end
    end
    fetch_ready_i = 1'b1;
    tick();
    #1;
    n_cmp++; if (pc_o !== 32'h14) begin n_err++; $display("FAIL bp_accept_pc actual=%h required=%h", pc_o, 32'h14); end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (fetch_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_valid%0d actual=%b required=0", i, fetch_valid_o); end
      tick();
      #1;
      n_cmp++; if (pc_o !== 32'h14) begin n_err++; $display("FAIL stall_pc%0d actual=%h required=%h", i, pc_o, 32'h14); end
    end
    stall_i = 1'b0;
    $display("backpressure: pc=%h", pc_o);
  endtask

  task automatic test_redirect_stall();
    stall_i = 1'b1; fetch_ready_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_target_i = 32'h2000;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (pc_o !== 32'h2000) begin n_err++; $display("FAIL redir_pc actual=%h required=%h", pc_o, 32'h2000); end
    n_cmp++; if (fetch_valid_o !== 1'b1) begin n_err++; $display("FAIL redir_valid actual=%b required=1", fetch_valid_o); end
    $display("redirect: pc=%h valid=%b", pc_o, fetch_valid_o);
  endtask

  task automatic test_misalign();
    fetch_ready_i = 1'b1;
    redirect_valid_i = 1'b1; redirect_target_i = 32'h2002;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (misalign_o !== 1'b1) begin n_err++; $display("FAIL mis_flag actual=%b required=1", misalign_o); end
    n_cmp++; if (misalign_addr_o !== 32'h2002) begin n_err++; $display("FAIL mis_addr actual=%h required=%h", misalign_addr_o, 32'h2002); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (pc_o !== 32'h2000) begin n_err++; $display("FAIL halt_pc%0d actual=%h required=%h", i, pc_o, 32'h2000); end
      n_cmp++; if (fetch_valid_o !== 1'b0) begin n_err++; $display("FAIL halt_valid%0d actual=%b required=0", i, fetch_valid_o); end
      tick();
      #1;
    end
    redirect_valid_i = 1'b1; redirect_target_i = 32'h3000;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (pc_o !== 32'h2000) begin n_err++; $display("FAIL halt_redir_pc actual=%h required=%h", pc_o, 32'h2000); end
    n_cmp++; if (misalign_o !== 1'b1) begin n_err++; $display("FAIL halt_redir_mis actual=%b required=1", misalign_o); end
    trap_valid_i = 1'b1; trap_vector_i = 32'h8003;
    tick();
    clear_inputs();
    fetch_ready_i = 1'b0;
    #1;
    n_cmp++; if (pc_o !== 32'h8000) begin n_err++; $display("FAIL trap_pc actual=%h required=%h", pc_o, 32'h8000); end
    n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL trap_mis actual=%b required=0", misalign_o); end
    n_cmp++; if (fetch_valid_o !== 1'b1) begin n_err++; $display("FAIL trap_valid actual=%b required=1", fetch_valid_o); end
    $display("misalign/trap: pc=%h misalign=%b", pc_o, misalign_o);
  endtask

  task automatic test_trap_priority();
    trap_valid_i = 1'b1; trap_vector_i = 32'h400;
    redirect_valid_i = 1'b1; redirect_target_i = 32'h999;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (pc_o !== 32'h400) begin n_err++; $display("FAIL prio_pc actual=%h required=%h", pc_o, 32'h400); end
    n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL prio_mis actual=%b required=0", misalign_o); end
    n_cmp++; if (fetch_valid_o !== 1'b1) begin n_err++; $display("FAIL prio_valid actual=%b required=1", fetch_valid_o); end
    $display("trap+redirect: pc=%h", pc_o);
  endtask

  task automatic test_wrap();
    fetch_ready_i = 1'b1;
    redirect_valid_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (pc_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc0 actual=%h required=%h", pc_o, 32'hFFFF_FFFC); end
    n_cmp++; if (pcp4_o !== 32'h0) begin n_err++; $display("FAIL wrap_pcp4 actual=%h required=0", pcp4_o); end
    tick();
    #1;
    n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL wrap_pc1 actual=%h required=0", pc_o); end
    n_cmp++; if (pcp4_o !== 32'h4) begin n_err++; $display("FAIL wrap_pcp4b actual=%h required=4", pcp4_o); end
    $display("wrap: pc=%h pcp4=%h", pc_o, pcp4_o);
  endtask

  task automatic test_trap_in_boot();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    trap_valid_i = 1'b1; trap_vector_i = 32'h500;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (pc_o !== 32'h500) begin n_err++; $display("FAIL boot_trap_pc actual=%h required=%h", pc_o, 32'h500); end
    n_cmp++; if (fetch_valid_o !== 1'b1) begin n_err++; $display("FAIL boot_trap_valid actual=%b required=1", fetch_valid_o); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    redirect_valid_i = 1'b1; redirect_target_i = 32'h600;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL boot_redir_pc actual=%h required=%h", pc_o, 32'h100); end
    $display("boot events: pc=%h", pc_o);
  endtask

  task automatic test_reset_mid();
    redirect_valid_i = 1'b1; redirect_target_i = 32'h2002;
    tick();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL rst_halt_pc actual=%h required=%h", pc_o, 32'h100); end
    n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL rst_halt_mis actual=%b required=0", misalign_o); end
    n_cmp++; if (misalign_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_halt_maddr actual=%h required=0", misalign_addr_o); end
    n_cmp++; if (fetch_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_halt_valid actual=%b required=0", fetch_valid_o); end
    tick();
    fetch_ready_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_target_i = 32'h40;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (fetch_valid_o !== 1'b1) begin n_err++; $display("FAIL pend_valid actual=%b required=1", fetch_valid_o); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (pc_o !== 32'h100) begin n_err++; $display("FAIL rst_pend_pc actual=%h required=%h", pc_o, 32'h100); end
    n_cmp++; if (fetch_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_pend_valid actual=%b required=0", fetch_valid_o); end
    $display("reset mid-op: pc=%h valid=%b", pc_o, fetch_valid_o);
  endtask

  initial begin
    rst = 1'b0;
    fetch_ready_i = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_stall();
    test_misalign();
    test_trap_priority();
    test_wrap();
    test_trap_in_boot();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV32I datapath, replacing the plain reset-or-load PC register. Holds the fetch address, presents it to instruction memory through a valid/ready handshake, and advances sequentially, on branch/jump redirect, or on trap entry. Detects misaligned redirect targets and halts fetch until a trap redirect arrives. Sits between the next-PC logic and the instruction-fetch port.

## Interface
- XLEN, 32: address width; all address ports are XLEN bits.
- RESET_VECTOR, 0: pc_o value loaded on reset; must be 4-byte aligned.
- STEP, 4: sequential increment in bytes.

- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  reset, synchronous, active-low.
- stall_i  input  1  hold PC and suppress the fetch request.
- redirect_valid_i  input  1  branch/jump taken this cycle.
- redirect_target_i  input  XLEN  branch/jump target address.
- trap_valid_i  input  1  trap or exception entry this cycle.
- trap_vector_i  input  XLEN  trap handler address.
- fetch_ready_i  input  1  instruction memory accepts the request.
- fetch_valid_o  output  1  fetch request valid at pc_o.
- pc_o  output  XLEN  current fetch address (registered).
- pcp4_o  output  XLEN  pc_o + STEP, combinational, mod 2^XLEN.
- misalign_o  output  1  misaligned redirect detected; high while HALT.
- misalign_addr_o  output  XLEN  offending target, registered with misalign_o.

## Operation
- States: BOOT, RUN, HALT.
- Reset (rst==0 at edge): state=BOOT, pc_o=RESET_VECTOR, misalign_o=0, misalign_addr_o=0, fetch_valid_o=0.
- BOOT → RUN unconditionally on the next edge; pc_o unchanged.
- fetch_valid_o = (state==RUN) && !stall_i && !redirect_valid_i && !trap_valid_i (combinational).
- Event priority per edge, highest first: rst, trap, redirect, handshake advance, hold.
- Trap (any state, including BOOT): pc_o ← trap_vector_i with bits [1:0] forced to 0; state ← RUN; misalign_o ← 0.
- Redirect (RUN only, ignored in BOOT/HALT):
  - target[1:0]==0: pc_o ← target; state stays RUN.
  - target[1:0]!=0: pc_o unchanged; state ← HALT; misalign_o ← 1; misalign_addr_o ← target.
- Advance: in RUN, fetch_valid_o && fetch_ready_i → pc_o ← pc_o + STEP, wrapping mod 2^XLEN.
- Otherwise pc_o holds, including a stalled cycle or an unaccepted request.
- Redirect and trap override stall_i.
- HALT: fetch_valid_o=0; pc_o and misalign_addr_o hold; exits only via trap or reset.

## Timing
- pc_o, state, misalign_o, misalign_addr_o are registered; one edge latency from any event.
- First fetch_valid_o=1 occurs one cycle after reset deasserts (BOOT cycle).
- Handshake: once fetch_valid_o=1, pc_o is stable until accepted. The request may be withdrawn only by stall_i, redirect_valid_i or trap_valid_i (flush).
- Redirect/trap cycle: no request is issued. The new pc_o is presented with fetch_valid_o=1 on the following cycle, unless stalled.
- Back-to-back accepted fetches: one address per cycle.
- Wrap: pc_o = 2^XLEN−STEP with handshake → pc_o = 0; pcp4_o also wraps.
- Reset mid-operation, including in HALT or while a request is pending: reset wins; any pending request is dropped.
- Simultaneous redirect and trap: trap wins; the redirect is discarded, including a misaligned one (no HALT entry).

## Test plan
- Reset then free run, RESET_VECTOR=0x100, ready=1: BOOT cycle valid=0, then pc_o=0x100,0x104,0x108 on consecutive cycles; pcp4_o=pc_o+4.
- Backpressure, ready=0 for 3 cycles at pc_o=0x10: valid stays 1 and pc_o stays 0x10; ready=1 → next pc_o=0x14. Repeat with stall_i=1: valid=0 and pc_o held.
- Redirect to 0x2000 while stall_i=1 and ready=0: next cycle pc_o=0x2000, valid=1.
- Misaligned redirect to 0x2002: misalign_o=1, misalign_addr_o=0x2002, pc_o unchanged, valid=0 for 5 idle cycles. Trap with vector 0x8003 → pc_o=0x8000, misalign_o=0, valid=1.
- Simultaneous trap (0x400) and redirect (0x999): pc_o=0x400, misalign_o stays 0. Wrap case: pc_o=0xFFFFFFFC accepted → pc_o=0x0.
- rst=0 asserted while in HALT and while a request is pending: next cycle state=BOOT, pc_o=RESET_VECTOR, misalign_o=0, valid=0.
